// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE sequencer.
// Op codes match the PE gemm_uno mode encoding.
package pe_pkg;

  localparam int INT_BW_DEF   = 5;
  localparam int FRA_BW_DEF   = 10;
  localparam int MUL_BW_DEF   = 16;
  localparam int ACC_BW_DEF   = 32;
  localparam int NUM_ITER_DEF = 8;
  localparam int CNT_BW       = 16;

  typedef enum logic [1:0] {
    OP_GEMM = 2'b00,
    OP_DIV  = 2'b01,
    OP_EXP  = 2'b10,
    OP_LOG  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_cnt.sv
// Iteration counter for the RUN phase; last flags the final RUN cycle.
module seq_cnt
  import pe_pkg::*;
#(
  parameter int W = CNT_BW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // target is never 0 when RUN is entered, so target-1 cannot wrap here.
  assign last = (cnt_q == target - W'(1));

endmodule

// File: rtl/uno_seq.sv
// Request sequencer for the gemm/div/exp/log PE: LOAD, iterate in RUN,
// take the PE result in DRAIN, then hold it in DONE until consumed.
module uno_seq
  import pe_pkg::*;
#(
  parameter int INT_BW   = INT_BW_DEF,
  parameter int FRA_BW   = FRA_BW_DEF,
  parameter int MUL_BW   = MUL_BW_DEF,
  parameter int ACC_BW   = ACC_BW_DEF,
  parameter int NUM_ITER = NUM_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [MUL_BW-1:0] req_x,
  input  logic [MUL_BW-1:0] req_y,
  input  logic [15:0]       req_len,
  input  logic              abort,
  output logic [1:0]        pe_mode,
  output logic [MUL_BW-1:0] pe_x,
  output logic [MUL_BW-1:0] pe_wc,
  input  logic [ACC_BW-1:0] pe_mac,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ACC_BW-1:0] rsp_data,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Operand format is sign + INT_BW + FRA_BW bits packed into MUL_BW.
  if (INT_BW + FRA_BW + 1 != MUL_BW) begin : g_fmt_chk
    $error("uno_seq: INT_BW + FRA_BW + 1 must equal MUL_BW");
  end

  // Handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both high; valid never depends on ready in this block.

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [MUL_BW-1:0] x_q, x_d;
  logic [MUL_BW-1:0] y_q, y_d;
  logic [15:0]       len_q, len_d;
  logic [ACC_BW-1:0] rsp_data_q, rsp_data_d;

  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_last;
  logic [15:0] target;
  logic        pe_active;

  assign target = (op_q == OP_GEMM) ? len_q : 16'(NUM_ITER);

  seq_cnt #(.W(16)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .target (target),
    .last   (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    len_d      = len_q;
    rsp_data_d = rsp_data_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    req_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d  = op_e'(req_op);
          x_d   = req_x;
          y_d   = req_y;
          len_d = req_len;
          // A zero-length gemm has nothing to iterate: answer 0 at once.
          if (op_e'(req_op) == OP_GEMM && req_len == 16'd0) begin
            rsp_data_d = '0;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        cnt_clr = 1'b1;
        state_d = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          rsp_data_d = pe_mac;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_GEMM;
      x_q        <= '0;
      y_q        <= '0;
      len_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      len_q      <= len_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign pe_active = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign pe_mode   = pe_active ? op_q : 2'b00;
  assign pe_x      = pe_active ? x_q : '0;
  assign pe_wc     = pe_active ? y_q : '0;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq: expected PE results are queued when the DRAIN
// cycle is driven and popped when the response is consumed.
module tb_uno_seq;
  import pe_pkg::*;

  localparam int MUL_BW   = 16;
  localparam int ACC_BW   = 32;
  localparam int NUM_ITER = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'b00;
  logic [MUL_BW-1:0] req_x = '0;
  logic [MUL_BW-1:0] req_y = '0;
  logic [15:0]       req_len = '0;
  logic              abort = 1'b0;
  logic [1:0]        pe_mode;
  logic [MUL_BW-1:0] pe_x;
  logic [MUL_BW-1:0] pe_wc;
  logic [ACC_BW-1:0] pe_mac = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ACC_BW-1:0] rsp_data;
  logic              busy;
  logic [2:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  logic [ACC_BW-1:0] exp_q[$];

  uno_seq #(
    .INT_BW(5), .FRA_BW(10), .MUL_BW(MUL_BW), .ACC_BW(ACC_BW), .NUM_ITER(NUM_ITER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_len   (req_len),
    .abort     (abort),
    .pe_mode   (pe_mode),
    .pe_x      (pe_x),
    .pe_wc     (pe_wc),
    .pe_mac    (pe_mac),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_pe_mode"}, 64'(pe_mode), 64'd0);
    chk({tag, "_pe_x"}, 64'(pe_x), 64'd0);
    chk({tag, "_pe_wc"}, 64'(pe_wc), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // kill_kind: 0 none, 1 abort, 2 reset, applied in cycle kill_k after the handshake.
  task automatic run_req(input string tag, input logic [1:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] len, input int hold,
                         input int kill_k, input int kill_kind, input bit abort_idle);
    int t;
    int k;
    bit got;
    logic [ACC_BW-1:0] exp_v;
    t = (op == 2'b00) ? int'(len) : NUM_ITER;
    chk({tag, "_req_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_len   = len;
    abort     = abort_idle;
    rsp_ready = (hold == 0);
    step();
    req_valid = 1'b0;
    abort     = 1'b0;
    k = 1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_req_ready_busy"}, 64'(req_ready), 64'd0);
    if (t == 0) begin
      chk({tag, "_zero_done"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_zero_pe_mode"}, 64'(pe_mode), 64'd0);
      exp_q.push_back('0);
    end else begin
      got = 1'b0;
      while (!got && k <= t + 10) begin
        if (rsp_valid) begin
          got = 1'b1;
        end else begin
          if (k <= t + 2 && (t <= 16 || k == 1 || k == t + 2)) begin
            chk($sformatf("%s_pe_mode_k%0d", tag, k), 64'(pe_mode), 64'(op));
            chk($sformatf("%s_pe_x_k%0d", tag, k), 64'(pe_x), 64'(x));
            chk($sformatf("%s_pe_wc_k%0d", tag, k), 64'(pe_wc), 64'(y));
          end
          if (k == kill_k) begin
            if (kill_kind == 1) abort = 1'b1;
            else rst_n = 1'b0;
            rsp_ready = 1'b0;
            step();
            abort = 1'b0;
            rst_n = 1'b1;
            chk_idle_outputs({tag, "_kill"});
            if (kill_kind == 2) chk({tag, "_rst_rsp_data"}, 64'(rsp_data), 64'd0);
            for (int i = 0; i < 3; i++) begin
              step();
              chk({tag, "_no_rsp"}, 64'(rsp_valid), 64'd0);
            end
            return;
          end
          pe_mac = $urandom;
          if (k == t + 2) exp_q.push_back(pe_mac);
          step();
          k++;
        end
      end
      chk({tag, "_latency"}, 64'(k), 64'(t + 3));
      if (!got) begin
        exp_q.delete();
        return;
      end
    end
    // DONE: hold off the consumer, try a new request and an abort meanwhile.
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      abort     = (i == 0);
      pe_mac    = $urandom;
      step();
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_data"}, 64'(rsp_data), 64'(exp_q[0]));
      chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    rsp_ready = 1'b1;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_req_ready_done"}, 64'(req_ready), 64'd0);
    exp_v = exp_q.pop_front();
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_v));
    step();
    rsp_ready = 1'b0;
    chk_idle_outputs({tag, "_after"});
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    step();

    run_req("exp",        2'b10, 16'h0400, 16'h0000, 16'd0, 0, 0, 0, 1'b0);
    run_req("gemm4",      2'b00, 16'd3,    16'd5,    16'd4, 0, 0, 0, 1'b0);
    run_req("gemm0",      2'b00, 16'd7,    16'd9,    16'd0, 2, 0, 0, 1'b0);
    run_req("div_abort",  2'b01, 16'h1234, 16'h0042, 16'd0, 0, 4, 1, 1'b0);
    run_req("log_hold",   2'b11, 16'h0C00, 16'h0011, 16'd0, 5, 0, 0, 1'b0);
    run_req("gemm_rst",   2'b00, 16'hFFFE, 16'h0003, 16'd3, 0, 3, 2, 1'b0);
    run_req("gemm_after", 2'b00, 16'h0002, 16'h8001, 16'd2, 1, 0, 0, 1'b0);
    run_req("drain_abort",2'b00, 16'h0005, 16'h0006, 16'd2, 0, 4, 1, 1'b0);
    run_req("idle_abort", 2'b01, 16'h0100, 16'h0200, 16'd0, 0, 0, 0, 1'b1);
    run_req("gemm1",      2'b00, 16'h7FFF, 16'h8000, 16'd1, 0, 0, 0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      run_req($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), 16'($urandom),
              16'($urandom), 16'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 0, 0, 1'b0);
    end
    run_req("gemm_max",   2'b00, 16'h0001, 16'h0001, 16'hFFFF, 0, 0, 0, 1'b0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
